timer_scheduler: RTL and testbench
==================================

# timer_scheduler

Round-robin scheduler that shares one interval timer between `R` requesters. Each requester raises a request with its own interval length. The scheduler grants the timer to one requester at a time, runs the count, and pulses that requester's `DONE` when the interval expires. It sits between the linked state machines and the shared timer resource, so the client FSMs do not need a timer each.

## Interface
Parameters:
- `R`, default 4: number of requesters (≥2).
- `W`, default 8: width of the interval-length and count fields.

Ports:
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `REQ` in R: per-requester request level, one bit per requester.
- `LEN` in R*W: per-requester interval length in cycles; requester i uses `LEN[i*W +: W]`.
- `GNT` out R: one-hot grant, or all zeros when no requester holds the timer.
- `DONE` out R: one-cycle pulse to the grantee when its interval expires.
- `ABORTED` out 1: one-cycle pulse when the grantee withdrew its request mid-interval.
- `BUSY` out 1: high while in RUN or FINISH.
- `ELAPSED` out W: cycles counted so far in the current interval; 0 when idle.

## Operation
- States: IDLE, RUN, FINISH.
- **IDLE**
  - If any `REQ` bit is high, select the first high bit searching upward from `ptr+1`, wrapping modulo R.
  - Latch that requester's `LEN` into `len_q`; a value of 0 is latched as 1.
  - Set `GNT` one-hot for the selected requester, clear the counter, and go to RUN.
  - With no requests, remain in IDLE.
- **RUN**
  - The counter increments every cycle and `ELAPSED` reflects it.
  - When the counter reaches `len_q-1`, go to FINISH.
  - If `REQ[g]` is low in any RUN cycle (g = grantee), abort:
    - pulse `ABORTED`;
    - clear `GNT` and the counter;
    - set `ptr` to g;
    - return to IDLE;
    - assert no `DONE`.
- **FINISH**
  - Lasts one cycle.
  - `DONE[g]` = 1 and `GNT[g]` stays 1.
  - On the next edge, set `ptr` to g, clear `GNT`, and return to IDLE.
  - `REQ[g]` is ignored in FINISH; it cannot abort here.
- Arbitration is plain round-robin.
  - Requests arriving while BUSY wait; there is no queueing beyond the `REQ` level.
  - A requester that keeps `REQ` high after `DONE` becomes eligible again, but only after every other pending requester is served.
- `LEN` is sampled only at grant; later changes to it have no effect on the running interval.
- `ptr` is `W`-independent, `$clog2(R)` bits wide, and wraps from R-1 to 0.

## Timing
- Reset values:
  - state = IDLE, `ptr` = R-1 (so requester 0 has priority first);
  - `GNT` = 0, `DONE` = 0, `ABORTED` = 0, `BUSY` = 0, `ELAPSED` = 0.
- Reset asserted mid-operation drops `GNT` immediately (asynchronously). No `DONE` or `ABORTED` is produced.
- All outputs are registered or decoded from the registered state, so there is no combinational path from `REQ` or `LEN`.
- Grant latency: `REQ` sampled high at edge k gives `GNT` high after edge k.
- A full interval of L ≥ 1 proceeds as follows:
  - L cycles in RUN, with `ELAPSED` going 0..L-1;
  - then 1 cycle in FINISH with `DONE` high;
  - `GNT` is high for L+1 cycles in total.
- There is at least one IDLE cycle between consecutive grants.
- Back-to-back pending requesters therefore see a grant period of L+2 cycles.
- Simultaneous events:
  - abort has priority over expiry in RUN;
  - if `REQ[g]` drops on the same cycle the count reaches `len_q-1`, the interval is aborted.

## Test plan
- **Single requester:** reset, then hold `REQ[2]`=1 with `LEN[2]`=5.
  - Expect `GNT`=0100 for 6 cycles and `ELAPSED` 0,1,2,3,4.
  - Expect `DONE[2]` pulsed in the 6th cycle, followed by 1 IDLE cycle with `GNT`=0.
- **Round-robin fairness:** all `REQ`=1111 held, all `LEN`=2.
  - Expect grant order 0,1,2,3,0, with each grant 3 cycles long, 1 idle cycle between grants, and one `DONE` per grant.
- **Zero and maximum length:**
  - `LEN`=0 → exactly 1 RUN cycle, then FINISH.
  - `LEN`=255 (W=8) → 255 RUN cycles, `ELAPSED` reaches 254, and there is no wrap.
- **Abort:**
  - `REQ[1]` with `LEN`=10, dropped after 3 RUN cycles.
  - Expect an `ABORTED` pulse, `GNT`=0 on the next cycle, and no `DONE[1]`.
  - A pending `REQ[3]` is granted after one IDLE cycle.
- **Simultaneous expiry and abort:** drop `REQ[g]` on the cycle with `ELAPSED`=`len_q-1`.
  - Expect `ABORTED`=1, `DONE`=0, and no FINISH state.
- **Async reset mid-RUN:** assert `RESET` between clock edges at `ELAPSED`=4.
  - `GNT`, `BUSY` and `ELAPSED` go to 0 without waiting for a clock edge.
  - After release with `REQ`=1111, requester 0 is granted first.

Source files
------------

// File: rtl/timer_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | timer_scheduler_if                                                           |
// | Request/grant bundle between client FSMs and the shared-timer scheduler.    |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
interface timer_scheduler_if #(
   parameter int R = 4,
   parameter int W = 8
);
   logic [R-1:0]   REQ;
   logic [R*W-1:0] LEN;
   logic [R-1:0]   GNT;
   logic [R-1:0]   DONE;
   logic           ABORTED;
   logic           BUSY;
   logic [W-1:0]   ELAPSED;

   modport master (
      output REQ, LEN,
      input  GNT, DONE, ABORTED, BUSY, ELAPSED
   );

   modport slave (
      input  REQ, LEN,
      output GNT, DONE, ABORTED, BUSY, ELAPSED
   );
endinterface
`default_nettype wire

// File: rtl/timer_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | timer_scheduler                                                              |
// | Round-robin sharing of one interval timer between R requesters.             |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module timer_scheduler #(
   parameter int R = 4,
   parameter int W = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   timer_scheduler_if.slave  bus
);

   localparam int PW = (R > 1) ? $clog2(R) : 1;
   localparam logic [W-1:0]  c_one     = {{(W-1){1'b0}}, 1'b1};
   localparam logic [R-1:0]  c_gnt_one = {{(R-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] c_ptr_rst = PW'(R - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] r_gidx;
   logic [R-1:0]  r_gnt;
   logic [W-1:0]  r_cnt;
   logic [W-1:0]  r_len;
   logic          r_aborted;

   logic [PW-1:0] w_sel;
   logic [PW-1:0] w_pos;
   logic          w_start;
   logic          w_abort;
   logic          w_expire;
   logic [W-1:0]  w_last;
   logic [W-1:0]  w_len_sel;
   logic [W-1:0]  w_len_arr [R];

   genvar gi;
   generate
      for (gi = 0; gi < R; gi++) begin : g_len
         assign w_len_arr[gi] = bus.LEN[gi*W +: W];
      end
   endgenerate

   // Walk downward so the nearest requester after ptr is the last one written.
   always_comb begin
      w_sel = r_ptr;
      w_pos = r_ptr;
      for (int k = R; k >= 1; k--) begin
         w_pos = PW'((int'(r_ptr) + k) % R);
         if (bus.REQ[w_pos]) begin
            w_sel = w_pos;
         end
      end
   end

   assign w_len_sel = w_len_arr[w_sel];
   assign w_last    = r_len - c_one;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_abort     = 1'b0;
      w_expire    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|bus.REQ) begin
               w_start     = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // A withdrawn request wins over a simultaneous expiry.
            if (!bus.REQ[r_gidx]) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == w_last) begin
               w_expire    = 1'b1;
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_ptr     <= c_ptr_rst;
         r_gidx    <= '0;
         r_gnt     <= '0;
         r_cnt     <= '0;
         r_len     <= c_one;
         r_aborted <= 1'b0;
      end else begin
         r_aborted <= w_abort;
         if (w_start) begin
            r_gidx <= w_sel;
            r_gnt  <= c_gnt_one << w_sel;
            r_len  <= (w_len_sel == '0) ? c_one : w_len_sel;
            r_cnt  <= '0;
         end else if (w_abort || r_state == S_FINISH) begin
            r_gnt <= '0;
            r_cnt <= '0;
            r_ptr <= r_gidx;
         end else if (r_state == S_RUN && !w_expire) begin
            r_cnt <= r_cnt + c_one;
         end
      end
   end

   assign bus.GNT     = r_gnt;
   assign bus.DONE    = (r_state == S_FINISH) ? r_gnt : '0;
   assign bus.ABORTED = r_aborted;
   assign bus.BUSY    = (r_state != S_IDLE);
   assign bus.ELAPSED = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_timer_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_timer_scheduler                                                           |
// | Directed vector table plus hand sequences for timer_scheduler.              |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_timer_scheduler;

   localparam int R = 4;
   localparam int W = 8;

   logic CLK = 1'b0;
   logic RESET;

   always #5 CLK = ~CLK;

   timer_scheduler_if #(.R(R), .W(W)) bus ();

   timer_scheduler #(.R(R), .W(W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   typedef struct {
      logic [R-1:0]   req;
      logic [R*W-1:0] len;
      logic           rst;
      logic [R-1:0]   gnt;
      logic [R-1:0]   done;
      logic           ab;
      logic           busy;
      logic [W-1:0]   el;
      logic           el_chk;
   } vec_t;

   vec_t tv[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [R*W-1:0] lens(input int l0, input int l1,
                                           input int l2, input int l3);
      return {W'(l3), W'(l2), W'(l1), W'(l0)};
   endfunction

   task automatic add(input logic [R-1:0] req, input logic [R*W-1:0] len,
                      input logic rst, input logic [R-1:0] gnt,
                      input logic [R-1:0] done, input logic ab, input logic busy,
                      input int el, input logic el_chk);
      vec_t v;
      v.req = req; v.len = len; v.rst = rst; v.gnt = gnt; v.done = done;
      v.ab = ab; v.busy = busy; v.el = W'(el); v.el_chk = el_chk;
      tv.push_back(v);
   endtask

   task automatic check(input string name, input logic [R-1:0] gnt,
                        input logic [R-1:0] done, input logic ab, input logic busy,
                        input logic [W-1:0] el, input logic el_chk);
      n_tests++;
      if (bus.GNT !== gnt || bus.DONE !== done || bus.ABORTED !== ab ||
          bus.BUSY !== busy || (el_chk && bus.ELAPSED !== el)) begin
         n_fail++;
         $display("FAIL %s: got gnt=%b done=%b ab=%b busy=%b el=%0d, expected gnt=%b done=%b ab=%b busy=%b el=%0d",
                  name, bus.GNT, bus.DONE, bus.ABORTED, bus.BUSY, bus.ELAPSED,
                  gnt, done, ab, busy, el);
      end
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      RESET = 1'b1;
      #2;
      RESET = 1'b0;
   endtask

   initial begin
      logic [R*W-1:0] l5, l2, l0, la, ls, lm, lr;
      RESET   = 1'b1;
      bus.REQ = '0;
      bus.LEN = '0;

      l5 = lens(0, 0, 5, 0);
      l2 = lens(2, 2, 2, 2);
      l0 = lens(0, 0, 0, 0);
      la = lens(0, 10, 0, 3);
      ls = lens(3, 0, 0, 0);

      // Single requester 2, LEN=5, then regrant and withdraw.
      add(4'b0100, l5, 1, 4'b0100, 4'b0000, 0, 1, 0, 1);
      for (int e = 1; e <= 4; e++) add(4'b0100, l5, 0, 4'b0100, 4'b0000, 0, 1, e, 1);
      add(4'b0100, l5, 0, 4'b0100, 4'b0100, 0, 1, 0, 0);
      add(4'b0100, l5, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);
      add(4'b0100, l5, 0, 4'b0100, 4'b0000, 0, 1, 0, 1);
      add(4'b0000, l5, 0, 4'b0000, 4'b0000, 1, 0, 0, 1);
      add(4'b0000, l5, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);

      // Round robin, all requesting with LEN=2: order 0,1,2,3,0.
      for (int n = 0; n < 5; n++) begin
         logic [R-1:0] g;
         g = 4'b0001 << (n % 4);
         add(4'b1111, l2, (n == 0), g, 4'b0000, 0, 1, 0, 1);
         add(4'b1111, l2, 0, g, 4'b0000, 0, 1, 1, 1);
         add(4'b1111, l2, 0, g, g, 0, 1, 0, 0);
         add(4'b1111, l2, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);
      end

      // LEN=0 behaves as one RUN cycle.
      add(4'b0001, l0, 1, 4'b0001, 4'b0000, 0, 1, 0, 1);
      add(4'b0001, l0, 0, 4'b0001, 4'b0001, 0, 1, 0, 0);
      add(4'b0000, l0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);

      // Abort of requester 1 after 3 RUN cycles; pending 3 follows.
      add(4'b1010, la, 1, 4'b0010, 4'b0000, 0, 1, 0, 1);
      add(4'b1010, la, 0, 4'b0010, 4'b0000, 0, 1, 1, 1);
      add(4'b1010, la, 0, 4'b0010, 4'b0000, 0, 1, 2, 1);
      add(4'b1000, la, 0, 4'b0000, 4'b0000, 1, 0, 0, 1);
      add(4'b1000, la, 0, 4'b1000, 4'b0000, 0, 1, 0, 1);
      add(4'b1000, la, 0, 4'b1000, 4'b0000, 0, 1, 1, 1);
      add(4'b1000, la, 0, 4'b1000, 4'b0000, 0, 1, 2, 1);
      add(4'b1000, la, 0, 4'b1000, 4'b1000, 0, 1, 0, 0);
      add(4'b0000, la, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);

      // Withdrawal on the expiry cycle aborts instead of finishing.
      add(4'b0001, ls, 1, 4'b0001, 4'b0000, 0, 1, 0, 1);
      add(4'b0001, ls, 0, 4'b0001, 4'b0000, 0, 1, 1, 1);
      add(4'b0001, ls, 0, 4'b0001, 4'b0000, 0, 1, 2, 1);
      add(4'b0000, ls, 0, 4'b0000, 4'b0000, 1, 0, 0, 1);
      add(4'b0000, ls, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);

      // Reset state.
      #3;
      check("reset_state", 4'b0000, 4'b0000, 0, 0, 0, 1);

      for (int i = 0; i < tv.size(); i++) begin
         if (tv[i].rst) pulse_reset();
         else @(negedge CLK);
         bus.REQ = tv[i].req;
         bus.LEN = tv[i].len;
         @(posedge CLK);
         #1;
         check($sformatf("vec%0d", i), tv[i].gnt, tv[i].done, tv[i].ab,
               tv[i].busy, tv[i].el, tv[i].el_chk);
      end

      // Maximum length 255: ELAPSED climbs to 254 without wrapping.
      lm = lens(255, 0, 0, 0);
      pulse_reset();
      bus.REQ = 4'b0001;
      bus.LEN = lm;
      for (int e = 0; e < 255; e++) begin
         @(posedge CLK);
         #1;
         check($sformatf("max_run%0d", e), 4'b0001, 4'b0000, 0, 1, W'(e), 1);
      end
      @(posedge CLK);
      #1;
      check("max_finish", 4'b0001, 4'b0001, 0, 1, 0, 0);
      @(negedge CLK);
      bus.REQ = 4'b0000;

      // Asynchronous reset between edges at ELAPSED=4.
      lr = lens(0, 0, 10, 0);
      pulse_reset();
      bus.REQ = 4'b0100;
      bus.LEN = lr;
      for (int e = 0; e < 5; e++) begin
         @(posedge CLK);
         #1;
      end
      check("areset_pre", 4'b0100, 4'b0000, 0, 1, 4, 1);
      #2;
      RESET = 1'b1;
      #1;
      check("areset_async", 4'b0000, 4'b0000, 0, 0, 0, 1);
      @(negedge CLK);
      bus.REQ = 4'b1111;
      bus.LEN = l2;
      RESET   = 1'b0;
      @(posedge CLK);
      #1;
      check("areset_first_gnt", 4'b0001, 4'b0000, 0, 1, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
